// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA shifter, STEP bits per cycle, start/ready/done handshake.
// Define SEQ_SHIFTER_ROTATE_EN to make op 11 a rotate-left; otherwise op 11 behaves as SLL.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   result_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHAMT_W-1:0] STEP_L = SHAMT_W'(STEP);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d, shifted;
  logic [SHAMT_W-1:0] rem_q, rem_d, k;
  logic [1:0] op_q, op_d;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q <= '0;
      rem_q <= '0;
      op_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      op_q <= op_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    k = rem_q < STEP_L ? rem_q : STEP_L;
`ifdef SEQ_SHIFTER_ROTATE_EN
    shifted = op_q == 2'b01 ? acc_q >> k :
              op_q == 2'b10 ? WIDTH'($signed(acc_q) >>> k) :
              op_q == 2'b11 ? (acc_q << k) | (acc_q >> ((SHAMT_W+1)'(WIDTH) - {1'b0, k})) :
              acc_q << k;
`else
    shifted = op_q == 2'b01 ? acc_q >> k :
              op_q == 2'b10 ? WIDTH'($signed(acc_q) >>> k) :
              acc_q << k;
`endif
  end
  // result_q loads on entry to DONE so result_o is valid in the same cycle as done_o
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    rem_d = rem_q;
    op_d = op_q;
    result_d = result_q;
    if (state_q == IDLE) begin
      if (start_i) begin
        acc_d = data_i;
        rem_d = shamt_i;
        op_d = op_i;
        state_d = shamt_i == '0 ? DONE : SHIFT;
        result_d = shamt_i == '0 ? data_i : result_q;
      end
    end else if (state_q == SHIFT) begin
      acc_d = shifted;
      rem_d = rem_q - k;
      state_d = rem_q <= STEP_L ? DONE : SHIFT;
      result_d = rem_q <= STEP_L ? shifted : result_q;
    end else begin
      state_d = IDLE;
    end
  end
  assign ready_o = state_q == IDLE;
  assign done_o = state_q == DONE;
  assign result_o = result_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized scoreboard bench for seq_shifter (WIDTH=32, STEP=4).
module tb_seq_shifter;
  localparam int WIDTH = 32;
  localparam int STEP = 4;
  typedef struct {
    logic [31:0] res;
    int lat;
    int issued;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] op = 0;
  logic [4:0] shamt = 0;
  logic [31:0] data = 0;
  logic ready, done;
  logic [31:0] result;
  exp_t q[$];
  exp_t e_mon;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] hold = 0;
  logic chk_ready = 0;

  seq_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .shamt_i(shamt),
    .data_i(data), .ready_o(ready), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] model(logic [1:0] o, logic [4:0] s, logic [31:0] d);
    logic [63:0] dd;
    dd = {d, d} << s;
    case (o)
      2'b01: return d >> s;
      2'b10: return 32'($signed(d) >>> s);
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11: return dd[63:32];
`endif
      default: return d << s;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
      chk_ready = 0;
    end else begin
      if (chk_ready) begin
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_done ready=%b expected 1", ready); end
      end
      chk_ready = 0;
      if (done) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done result=%h with nothing outstanding", result);
        end else begin
          e_mon = q.pop_front();
          checks += 2;
          if (result !== e_mon.res) begin errors++; $display("FAIL result got=%h expected=%h", result, e_mon.res); end
          if (cyc - e_mon.issued != e_mon.lat) begin errors++; $display("FAIL latency got=%0d expected=%0d", cyc - e_mon.issued, e_mon.lat); end
          hold = e_mon.res;
          chk_ready = 1;
        end
      end else begin
        checks++;
        if (result !== hold) begin errors++; $display("FAIL result_hold got=%h expected=%h", result, hold); end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d, input bit junk);
    int n = 0;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout ready=%b expected 1", ready);
      return;
    end
    start = 1; op = o; shamt = s; data = d;
    q.push_back('{model(o, s, d), (int'(s) + STEP - 1) / STEP + 1, cyc});
    @(negedge clk);
    start = 0;
    if (junk) begin
      start = 1; op = 2'($urandom); shamt = 5'($urandom); data = $urandom;
      @(negedge clk);
      start = 0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain_timeout outstanding=%0d expected 0", q.size()); q.delete(); end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checks += 3;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b expected 1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b expected 0", done); end
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h expected 0", result); end
    @(negedge clk); #2 rst = 0;
    @(negedge clk);
    issue(2'b00, 5'd2, 32'h0000_0001, 0);
    issue(2'b10, 5'd31, 32'h8000_0000, 0);
    issue(2'b01, 5'd31, 32'h8000_0000, 0);
    issue(2'b00, 5'd0, 32'hDEAD_BEEF, 0);
    issue(2'b10, 5'd0, 32'hDEAD_BEEF, 0);
    issue(2'b11, 5'd0, 32'hDEAD_BEEF, 0);
    issue(2'b11, 5'd4, 32'h8000_0001, 0);
    issue(2'b11, 5'd13, 32'hF000_000F, 0);
    issue(2'b01, 5'd9, 32'hCAFE_F00D, 1);
    issue(2'b10, 5'd1, 32'h9000_0000, 1);
    issue(2'b00, 5'd4, 32'h1234_5678, 1);
    issue(2'b10, 5'd5, 32'h7FFF_FFFF, 0);
    drain();
    issue(2'b10, 5'd31, 32'h8000_0000, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    q.delete();
    #1;
    checks += 3;
    if (ready !== 1'b1) begin errors++; $display("FAIL midshift_reset_ready got=%b expected 1", ready); end
    if (done !== 1'b0) begin errors++; $display("FAIL midshift_reset_done got=%b expected 0", done); end
    if (result !== 32'h0) begin errors++; $display("FAIL midshift_reset_result got=%h expected 0", result); end
    @(negedge clk); #2 rst = 0;
    repeat (15) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b expected 1", ready); end
    repeat (150) issue(2'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3) == 0);
    issue(2'b00, 5'd31, 32'hFFFF_FFFF, 0);
    issue(2'b01, 5'd31, 32'hFFFF_FFFF, 0);
    issue(2'b10, 5'd31, 32'h7FFF_FFFF, 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
